// File: rtl/fpga.sv
// fpga: 32-cell LUT4 fabric with 160 perimeter pins, configured by 43 frames of 224 bits.
// Optional build macro FPGA_CFG_RESET_EN: rst also clears configuration memory and flip-flops.
module fpga (
    input  logic         clock,
    input  logic         rst,
    input  logic         ff_en,
    input  logic [42:0]  configs_en,
    input  logic [223:0] configs_in,
    input  logic [39:0]  top_in,
    input  logic [39:0]  bot_in,
    input  logic [39:0]  left_in,
    input  logic [39:0]  right_in,
    output logic [39:0]  top_out,
    output logic [39:0]  bot_out,
    output logic [39:0]  left_out,
    output logic [39:0]  right_out
);

    logic [223:0] r_cfg [0:42];
    logic [31:0]  r_q;
    logic [31:0]  w_cells;
    logic [31:0]  w_l;
    logic [255:0] w_src;
    logic [159:0] w_pins;
    logic         w_unused;

    function automatic logic lut_eval(input logic [255:0] s, input logic [47:0] c);
        logic [3:0]  idx;
        logic [15:0] lut;
        idx = {s[c[31:24]], s[c[23:16]], s[c[15:8]], s[c[7:0]]};
        lut = c[47:32];
        return lut[idx];
    endfunction

    // Cell-to-cell combinational chains are resolved by 32 unrolled evaluation passes, which
    // settles any loop-free chain of up to 32 cells without a structural loop in the netlist.
    always_comb begin
        logic [255:0] w_s;
        logic [31:0]  w_nxt;
        w_s     = '0;
        w_nxt   = '0;
        w_cells = r_q;
        for (int n = 0; n < 32; n++) begin
            w_s = {1'b1, 63'd0, w_cells, right_in, left_in, bot_in, top_in};
            for (int k = 0; k < 32; k++) begin
                w_nxt[k] = r_cfg[k][48] ? r_q[k] : lut_eval(w_s, r_cfg[k][47:0]);
            end
            w_cells = w_nxt;
        end
    end

    assign w_src = {1'b1, 63'd0, w_cells, right_in, left_in, bot_in, top_in};

    always_comb begin
        w_l = '0;
        for (int k = 0; k < 32; k++) begin
            w_l[k] = lut_eval(w_src, r_cfg[k][47:0]);
        end
    end

    // Pin p lives in frame 32 + p/20, slot p%20: {enable, select[7:0]}.
    always_comb begin
        logic [223:0] w_fr;
        logic [8:0]   w_slot;
        w_fr   = '0;
        w_slot = '0;
        w_pins = '0;
        for (int p = 0; p < 160; p++) begin
            w_fr      = r_cfg[32 + p / 20];
            w_slot    = w_fr[9 * (p % 20) +: 9];
            w_pins[p] = w_slot[8] & w_src[w_slot[7:0]];
        end
    end

    assign top_out   = w_pins[39:0];
    assign bot_out   = w_pins[79:40];
    assign left_out  = w_pins[119:80];
    assign right_out = w_pins[159:120];

    always_ff @(posedge clock) begin
        if (rst) begin
`ifdef FPGA_CFG_RESET_EN
            r_q <= '0;
`else
            r_q <= r_cfg[40][31:0];
`endif
        end else if (ff_en) begin
            r_q <= w_l;
        end
    end

`ifdef FPGA_CFG_RESET_EN
    always_ff @(posedge clock) begin
        for (int i = 0; i < 43; i++) begin
            if (rst) begin
                r_cfg[i] <= '0;
            end else if (configs_en[i]) begin
                r_cfg[i] <= configs_in;
            end
        end
    end
`else
    always_ff @(posedge clock) begin
        for (int i = 0; i < 43; i++) begin
            if (configs_en[i]) begin
                r_cfg[i] <= configs_in;
            end
        end
    end
`endif

    // Ignored and reserved frame bits are kept writable but have no function.
    always_comb begin
        w_unused = ^{r_cfg[40][223:32], r_cfg[41], r_cfg[42]};
        for (int k = 0; k < 32; k++) begin
            w_unused = w_unused ^ (^r_cfg[k][223:49]);
        end
        for (int j = 32; j < 40; j++) begin
            w_unused = w_unused ^ (^r_cfg[j][223:180]);
        end
    end

endmodule

// File: tb/tb_fpga.sv
// tb_fpga: randomized and directed checks of the fpga fabric against a behavioural model.
module tb_fpga;

    logic         clock = 1'b0;
    logic         rst;
    logic         ff_en;
    logic [42:0]  configs_en;
    logic [223:0] configs_in;
    logic [39:0]  top_in, bot_in, left_in, right_in;
    logic [39:0]  top_out, bot_out, left_out, right_out;

    int total = 0;
    int bad   = 0;

    logic [223:0] m_cfg [0:42];
    logic [31:0]  m_q;

    fpga dut (
        .clock      (clock),
        .rst        (rst),
        .ff_en      (ff_en),
        .configs_en (configs_en),
        .configs_in (configs_in),
        .top_in     (top_in),
        .bot_in     (bot_in),
        .left_in    (left_in),
        .right_in   (right_in),
        .top_out    (top_out),
        .bot_out    (bot_out),
        .left_out   (left_out),
        .right_out  (right_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [159:0] dut_pins();
        return {right_out, left_out, bot_out, top_out};
    endfunction

    function automatic logic m_lut(input int k, input logic [255:0] s);
        logic [15:0] lt;
        logic [3:0]  idx;
        lt  = m_cfg[k][47:32];
        idx = {s[m_cfg[k][31:24]], s[m_cfg[k][23:16]], s[m_cfg[k][15:8]], s[m_cfg[k][7:0]]};
        return lt[idx];
    endfunction

    // Source bus with cell outputs settled by repeated in-place sweeps.
    function automatic logic [255:0] m_src();
        logic [31:0]  c;
        logic [255:0] s;
        c = '0;
        s = '0;
        for (int it = 0; it < 34; it++) begin
            for (int k = 0; k < 32; k++) begin
                s = {1'b1, 63'd0, c, right_in, left_in, bot_in, top_in};
                c[k] = m_cfg[k][48] ? m_q[k] : m_lut(k, s);
            end
        end
        return {1'b1, 63'd0, c, right_in, left_in, bot_in, top_in};
    endfunction

    function automatic logic [159:0] m_pins();
        logic [255:0] s;
        logic [159:0] r;
        logic [223:0] f;
        int           b;
        s = m_src();
        r = '0;
        for (int p = 0; p < 160; p++) begin
            f = m_cfg[32 + p / 20];
            b = 9 * (p % 20);
            r[p] = f[b + 8] ? s[f[b +: 8]] : 1'b0;
        end
        return r;
    endfunction

    task automatic tick();
        logic [255:0] s;
        logic [31:0]  qn;
        logic [223:0] nc [0:42];
        s  = m_src();
        qn = m_q;
        for (int i = 0; i < 43; i++) nc[i] = m_cfg[i];
`ifdef FPGA_CFG_RESET_EN
        if (rst) begin
            qn = '0;
            for (int i = 0; i < 43; i++) nc[i] = '0;
        end else begin
            if (ff_en) for (int k = 0; k < 32; k++) qn[k] = m_lut(k, s);
            for (int i = 0; i < 43; i++) if (configs_en[i]) nc[i] = configs_in;
        end
`else
        if (rst) qn = m_cfg[40][31:0];
        else if (ff_en) for (int k = 0; k < 32; k++) qn[k] = m_lut(k, s);
        for (int i = 0; i < 43; i++) if (configs_en[i]) nc[i] = configs_in;
`endif
        @(posedge clock);
        #1;
        m_q = qn;
        for (int i = 0; i < 43; i++) m_cfg[i] = nc[i];
    endtask

    task automatic set_frame(input int i, input logic [223:0] d);
        configs_en = 43'd1 << i;
        configs_in = d;
        tick();
        configs_en = '0;
    endtask

    task automatic set_pin(input int p, input logic [7:0] sel, input logic en);
        logic [223:0] d;
        d = m_cfg[32 + p / 20];
        d[9 * (p % 20) +: 9] = {en, sel};
        set_frame(32 + p / 20, d);
    endtask

    function automatic logic [223:0] cell_frame(input logic [7:0] s0, input logic [7:0] s1,
                                                input logic [7:0] s2, input logic [7:0] s3,
                                                input logic [15:0] lut, input logic ff);
        return {175'd0, ff, lut, s3, s2, s1, s0};
    endfunction

    function automatic logic [223:0] rnd224();
        logic [223:0] d;
        for (int i = 0; i < 7; i++) d[32 * i +: 32] = $urandom;
        return d;
    endfunction

    // Cells only reference lower-numbered cells, so random configurations stay loop-free.
    function automatic logic [7:0] rnd_sel(input int k);
        int c;
        c = $urandom_range(0, 3);
        if (c == 1 && k > 0) return 8'(160 + $urandom_range(0, k - 1));
        if (c == 2) return 8'($urandom_range(192, 255));
        return 8'($urandom_range(0, 159));
    endfunction

    task automatic rnd_inputs();
        top_in   = {$urandom, $urandom}[39:0];
        bot_in   = {$urandom, $urandom}[39:0];
        left_in  = {$urandom, $urandom}[39:0];
        right_in = {$urandom, $urandom}[39:0];
    endtask

    initial begin
        logic [223:0] d;
        rst = 0; ff_en = 0; configs_en = '0; configs_in = '0;
        top_in = '0; bot_in = '0; left_in = '0; right_in = '0;
        for (int i = 0; i < 43; i++) m_cfg[i] = '0;
        m_q = '0;
        @(negedge clock);

        configs_en = '1; configs_in = '0; tick(); configs_en = '0;
        rst = 1; tick(); rst = 0;
        chk("reset_zero", dut_pins(), 160'd0);
        chk("reset_model", dut_pins(), m_pins());

        // inverter
        set_frame(0, cell_frame(8'd0, 8'd0, 8'd0, 8'd0, 16'h5555, 1'b0));
        set_pin(2, 8'd160, 1'b1);
        top_in[0] = 1; #1;
        chk("inv_hi", {159'd0, top_out[2]}, 160'd0);
        top_in[0] = 0; #1;
        chk("inv_lo", {159'd0, top_out[2]}, 160'd1);
        chk("inv_model", dut_pins(), m_pins());

        // registered path
        set_frame(0, cell_frame(8'd0, 8'd0, 8'd0, 8'd0, 16'h5555, 1'b1));
        ff_en = 1; top_in[0] = 0; #1;
        chk("reg_before", {159'd0, top_out[2]}, 160'd0);
        tick();
        chk("reg_after", {159'd0, top_out[2]}, 160'd1);
        top_in[0] = 1; tick();
        chk("reg_after2", {159'd0, top_out[2]}, 160'd0);
        ff_en = 0;
        for (int i = 0; i < 5; i++) begin
            top_in[0] = ~top_in[0];
            tick();
            chk("reg_hold", {159'd0, top_out[2]}, 160'd0);
        end

        // reset loads frame 40 init values
        set_frame(40, 224'd1);
        rst = 1; tick(); rst = 0;
`ifndef FPGA_CFG_RESET_EN
        chk("rst_q0", {159'd0, top_out[2]}, 160'd1);
`endif
        chk("rst_model", dut_pins(), m_pins());
        set_frame(0, cell_frame(8'd0, 8'd0, 8'd0, 8'd0, 16'h5555, 1'b0));
        top_in[0] = 1; #1;
        chk("rst_inv_model", dut_pins(), m_pins());
`ifndef FPGA_CFG_RESET_EN
        chk("rst_inv_hi", {159'd0, top_out[2]}, 160'd0);
`endif

        // rst and frame 40 write on the same edge
        set_frame(0, cell_frame(8'd0, 8'd0, 8'd0, 8'd0, 16'h5555, 1'b1));
        rst = 1; configs_en = 43'd1 << 40; configs_in = '0; tick();
        configs_en = '0;
`ifndef FPGA_CFG_RESET_EN
        chk("rst_wr_old", {159'd0, top_out[2]}, 160'd1);
`endif
        chk("rst_wr_model", dut_pins(), m_pins());
        tick(); rst = 0;
        chk("rst_wr_new", dut_pins(), m_pins());

        // all pins disabled
        configs_en = 43'hFF << 32; configs_in = '0; tick(); configs_en = '0;
        for (int i = 0; i < 4; i++) begin
            rnd_inputs(); #1;
            chk("pins_off", dut_pins(), 160'd0);
        end
        set_pin(159, 8'd255, 1'b1);
        chk("right39", {159'd0, right_out[39]}, 160'd1);
        chk("right39_model", dut_pins(), m_pins());

        // one write, two frames
        d = cell_frame(8'd40, 8'd41, 8'd255, 8'd0, 16'($urandom), 1'b0);
        configs_en = 43'h3; configs_in = d; tick(); configs_en = '0;
        set_pin(0, 8'd160, 1'b1);
        set_pin(1, 8'd161, 1'b1);
        for (int i = 0; i < 6; i++) begin
            rnd_inputs(); #1;
            chk("multi", dut_pins(), m_pins());
        end

        // randomized configurations and operation
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 32; k++) begin
                d = rnd224();
                d[7:0] = rnd_sel(k); d[15:8] = rnd_sel(k);
                d[23:16] = rnd_sel(k); d[31:24] = rnd_sel(k);
                d[48] = 1'($urandom_range(0, 1));
                ff_en = 1'($urandom_range(0, 1));
                rnd_inputs();
                set_frame(k, d);
            end
            for (int j = 32; j < 43; j++) begin
                rnd_inputs();
                set_frame(j, rnd224());
            end
            chk("rnd_cfg", dut_pins(), m_pins());
            for (int c = 0; c < 20; c++) begin
                rnd_inputs();
                ff_en = 1'($urandom_range(0, 1));
                rst = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 4) == 0) begin
                    configs_en = 43'd1 << $urandom_range(40, 42);
                    configs_in = rnd224();
                end
                tick();
                configs_en = '0;
                rst = 0;
                chk("rnd_tick", dut_pins(), m_pins());
                rnd_inputs(); #1;
                chk("rnd_comb", dut_pins(), m_pins());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
